// File: rtl/max7219_pkg.sv
// Shared types and MAX7219 register map for the frame arbiter.
// Optional build macro used by this slice: MAX7219_ARB_FIXED_PRIO_EN.
package max7219_pkg;

    localparam logic [3:0] NOOP        = 4'h0;
    localparam logic [3:0] DIGIT0      = 4'h1;
    localparam logic [3:0] DIGIT1      = 4'h2;
    localparam logic [3:0] DIGIT2      = 4'h3;
    localparam logic [3:0] DIGIT3      = 4'h4;
    localparam logic [3:0] DIGIT4      = 4'h5;
    localparam logic [3:0] DIGIT5      = 4'h6;
    localparam logic [3:0] DIGIT6      = 4'h7;
    localparam logic [3:0] DIGIT7      = 4'h8;
    localparam logic [3:0] DECODEMODE  = 4'h9;
    localparam logic [3:0] INTENSITY   = 4'hA;
    localparam logic [3:0] SCANLIMIT   = 4'hB;
    localparam logic [3:0] SHUTDOWN    = 4'hC;
    localparam logic [3:0] DISPLAYTEST = 4'hF;

    typedef enum logic [3:0] {
        ST_FLUSH_HI,
        ST_FLUSH_LO,
        ST_ARB,
        ST_HI_START,
        ST_HI_WAIT,
        ST_LO_START,
        ST_LO_WAIT,
        ST_LOAD,
        ST_GAP
    } arb_state_e;

    // One 16-bit MAX7219 shift frame; the top nibble is always zero.
    typedef struct packed {
        logic [3:0] pad;
        logic [3:0] addr;
        logic [7:0] data;
    } max_frame_t;

    function automatic logic [7:0] frame_hi(input max_frame_t f);
        return {f.pad, f.addr};
    endfunction

endpackage

// File: rtl/max7219_rr_arb.sv
// Grant selection for the frame arbiter: round-robin from a pointer register,
// or fixed lowest-index priority when MAX7219_ARB_FIXED_PRIO_EN is defined.
module max7219_rr_arb
    import max7219_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             advance_i,
    output logic [N_REQ-1:0] grant_c_o,
    output logic             any_c_o
);

    assign any_c_o = |req_i;

`ifdef MAX7219_ARB_FIXED_PRIO_EN

    logic found_c;
    logic unused_ok;
    assign unused_ok = ^{clk, rst, advance_i};

    always_comb begin
        grant_c_o = '0;
        found_c   = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (!found_c && req_i[k]) begin
                grant_c_o[k] = 1'b1;
                found_c      = 1'b1;
            end
        end
    end

`else

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx_c;
    logic [31:0]   cand_c;
    logic          found_c;

    // First requester at or after the pointer, wrapping past N_REQ-1.
    always_comb begin
        grant_c_o = '0;
        idx_c     = '0;
        found_c   = 1'b0;
        cand_c    = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand_c = 32'(ptr_q) + 32'(k);
            if (cand_c >= 32'(N_REQ)) begin
                cand_c = cand_c - 32'(N_REQ);
            end
            if (!found_c && req_i[cand_c[PW-1:0]]) begin
                grant_c_o[cand_c[PW-1:0]] = 1'b1;
                idx_c                     = cand_c[PW-1:0];
                found_c                   = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found_c) begin
            if (idx_c == PW'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = idx_c + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/max7219_frame_arbiter.sv
// Arbitrates N register-write requesters onto one byte-wide SPI master and frames
// each grant as a MAX7219 16-bit write. Build option: MAX7219_ARB_FIXED_PRIO_EN.
module max7219_frame_arbiter
    import max7219_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned LOAD_HOLD  = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [4*N_REQ-1:0] req_addr_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic               spi_start_o,
    output logic [7:0]         spi_data_o,
    input  logic               spi_busy_i,
    output logic               max_load_o,
    output logic               frame_done_o,
    output logic               idle_o
);

    // The ARB cycle that grants the next frame is the last cycle of the load hold.
    localparam int unsigned HOLD_CYC = LOAD_HOLD - 1;
    localparam int unsigned CNT_MAX  = (HOLD_CYC > GAP_CYCLES) ? HOLD_CYC : GAP_CYCLES;
    localparam int unsigned CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    arb_state_e       state_q;
    max_frame_t       frame_q;
    logic [CW-1:0]    cnt_q;
    logic             first_q;
    logic             flush_q;
    logic [N_REQ-1:0] req_ready_q;
    logic             spi_start_q;
    logic [7:0]       spi_data_q;
    logic             max_load_q;
    logic             frame_done_q;
    logic             idle_q;

    logic [N_REQ-1:0] grant_c;
    logic             any_c;
    logic             arb_c;
    max_frame_t       sel_frame_c;

    assign arb_c = (state_q == ST_ARB);

    max7219_rr_arb #(
        .N_REQ(N_REQ)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_valid_i),
        .advance_i(arb_c),
        .grant_c_o(grant_c),
        .any_c_o  (any_c)
    );

    always_comb begin
        sel_frame_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant_c[i]) begin
                sel_frame_c.addr = req_addr_i[4*i +: 4];
                sel_frame_c.data = req_data_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FLUSH_HI;
            frame_q      <= '0;
            cnt_q        <= '0;
            first_q      <= 1'b0;
            flush_q      <= 1'b1;
            req_ready_q  <= '0;
            spi_start_q  <= 1'b0;
            spi_data_q   <= '0;
            max_load_q   <= 1'b0;
            frame_done_q <= 1'b0;
            idle_q       <= 1'b0;
        end else begin
            req_ready_q  <= '0;
            spi_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            idle_q       <= 1'b0;
            unique case (state_q)
                ST_FLUSH_HI: begin
                    spi_start_q <= 1'b1;
                    spi_data_q  <= {4'h0, NOOP};
                    state_q     <= ST_HI_START;
                end
                ST_FLUSH_LO: begin
                    spi_start_q <= 1'b1;
                    spi_data_q  <= 8'h00;
                    flush_q     <= 1'b0;
                    state_q     <= ST_LO_START;
                end
                ST_ARB: begin
                    if (any_c) begin
                        req_ready_q <= grant_c;
                        frame_q     <= sel_frame_c;
                        max_load_q  <= 1'b0;
                        spi_start_q <= 1'b1;
                        spi_data_q  <= frame_hi(sel_frame_c);
                        state_q     <= ST_HI_START;
                    end else begin
                        idle_q <= 1'b1;
                    end
                end
                ST_HI_START: begin
                    first_q <= 1'b1;
                    state_q <= ST_HI_WAIT;
                end
                // Busy is not trusted on the first wait cycle after a start.
                ST_HI_WAIT: begin
                    if (first_q) begin
                        first_q <= 1'b0;
                    end else if (!spi_busy_i) begin
                        if (flush_q) begin
                            state_q <= ST_FLUSH_LO;
                        end else begin
                            spi_start_q <= 1'b1;
                            spi_data_q  <= frame_q.data;
                            state_q     <= ST_LO_START;
                        end
                    end
                end
                ST_LO_START: begin
                    first_q <= 1'b1;
                    state_q <= ST_LO_WAIT;
                end
                ST_LO_WAIT: begin
                    if (first_q) begin
                        first_q <= 1'b0;
                    end else if (!spi_busy_i) begin
                        max_load_q   <= 1'b1;
                        frame_done_q <= 1'b1;
                        if (HOLD_CYC != 0) begin
                            cnt_q   <= CW'(HOLD_CYC - 1);
                            state_q <= ST_LOAD;
                        end else if (GAP_CYCLES != 0) begin
                            cnt_q   <= CW'(GAP_CYCLES - 1);
                            state_q <= ST_GAP;
                        end else begin
                            state_q <= ST_ARB;
                        end
                    end
                end
                ST_LOAD: begin
                    if (cnt_q == '0) begin
                        if (GAP_CYCLES != 0) begin
                            cnt_q   <= CW'(GAP_CYCLES - 1);
                            state_q <= ST_GAP;
                        end else begin
                            state_q <= ST_ARB;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_ARB;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= ST_FLUSH_HI;
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign spi_start_o  = spi_start_q;
    assign spi_data_o   = spi_data_q;
    assign max_load_o   = max_load_q;
    assign frame_done_o = frame_done_q;
    assign idle_o       = idle_q;

endmodule

// File: tb/tb_max7219_frame_arbiter.sv
// Scoreboard bench for max7219_frame_arbiter with a busy-raising SPI master model.
module tb_max7219_frame_arbiter;

    localparam int unsigned N   = 2;
    localparam int unsigned LH  = 4;
    localparam int unsigned GAP = 0;
    localparam int unsigned T   = 22;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid;
    logic [7:0]  req_addr;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        spi_start;
    logic [7:0]  spi_data;
    logic        spi_busy;
    logic        max_load;
    logic        frame_done;
    logic        idle;

    always #5 clk = ~clk;

    max7219_frame_arbiter #(
        .N_REQ     (N),
        .LOAD_HOLD (LH),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .spi_start_o (spi_start),
        .spi_data_o  (spi_data),
        .spi_busy_i  (spi_busy),
        .max_load_o  (max_load),
        .frame_done_o(frame_done),
        .idle_o      (idle)
    );

    // SPI master model: busy rises with start and lasts T cycles.
    int unsigned spi_cnt;
    assign spi_busy = spi_start | (spi_cnt != 0);
    always @(posedge clk) begin
        if (rst)            spi_cnt <= 0;
        else if (spi_start) spi_cnt <= T - 1;
        else if (spi_cnt != 0) spi_cnt <= spi_cnt - 1;
    end

    logic [7:0] exp_bytes[$];
    int         exp_grants[$];
    int checks = 0;
    int errors = 0;
    int n_frames = 0;
    int n_starts = 0;
    int starts_in_frame = 0;
    int hi_len = 0;
    int last_hi_len = 0;
    logic busy_prev = 1'b0;
    logic ml_prev = 1'b0;

    // Monitor: pops expectations whenever the DUT presents a byte or a grant.
    always @(negedge clk) begin
        logic [7:0] eb;
        logic [1:0] eoh;
        if (rst) begin
            starts_in_frame = 0;
            hi_len = 0;
            busy_prev = 1'b0;
            ml_prev = 1'b0;
        end else begin
            if (spi_start) begin
                n_starts++;
                starts_in_frame++;
                checks++;
                if (busy_prev) begin
                    errors++;
                    $display("FAIL start_while_busy: start seen with busy high the cycle before");
                end
                checks++;
                if (exp_bytes.size() == 0) begin
                    errors++;
                    $display("FAIL spi_byte: got unexpected byte %02h, required none", spi_data);
                end else begin
                    eb = exp_bytes.pop_front();
                    if (spi_data !== eb) begin
                        errors++;
                        $display("FAIL spi_byte: got %02h, required %02h", spi_data, eb);
                    end
                end
            end
            if (req_ready != 2'b00) begin
                checks++;
                if (exp_grants.size() == 0) begin
                    errors++;
                    $display("FAIL grant: got req_ready %b, required none", req_ready);
                end else begin
                    eoh = 2'b01 << exp_grants.pop_front();
                    if (req_ready !== eoh) begin
                        errors++;
                        $display("FAIL grant: got req_ready %b, required %b", req_ready, eoh);
                    end
                end
            end
            if (frame_done || (max_load && !ml_prev)) begin
                checks++;
                if (!(frame_done && max_load && !ml_prev)) begin
                    errors++;
                    $display("FAIL load_rise: frame_done %b max_load %b prev %b, required 1 1 0",
                             frame_done, max_load, ml_prev);
                end
                checks++;
                if (starts_in_frame != 2) begin
                    errors++;
                    $display("FAIL starts_per_frame: got %0d, required 2", starts_in_frame);
                end
                starts_in_frame = 0;
                n_frames++;
            end
            if (!max_load && ml_prev) begin
                last_hi_len = hi_len;
                checks++;
                if (req_ready == 2'b00) begin
                    errors++;
                    $display("FAIL load_fall: max_load fell with req_ready %b, required a grant", req_ready);
                end
            end
            if (max_load) hi_len = ml_prev ? hi_len + 1 : 1;
            busy_prev = spi_busy;
            ml_prev = max_load;
        end
    end

    task automatic check_val(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_val(name, int'({req_ready, spi_start, spi_data, max_load, frame_done, idle}), 0);
    endtask

    task automatic wait_frames(input int target, input string name);
        int cyc = 0;
        while (n_frames < target && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check_val(name, n_frames, target);
    endtask

    task automatic wait_starts(input int target, input string name);
        int cyc = 0;
        while (n_starts < target && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check_val(name, n_starts, target);
    endtask

    task automatic request(input int i, input logic [3:0] a, input logic [7:0] d);
        int cyc = 0;
        req_addr[4*i +: 4] = a;
        req_data[8*i +: 8] = d;
        req_valid[i] = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
        end while (!req_ready[i] && cyc < 3000);
        req_valid[i] = 1'b0;
        if (cyc >= 3000) check_val("request_timeout", 0, 1);
    endtask

    initial begin
        int grants;
        int cyc;
        int s0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h00);
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;

        wait_frames(1, "flush_frame");
        repeat (LH + GAP + 3) @(negedge clk);
        check_val("idle_after_flush", int'(idle), 1);
        check_val("load_high_when_idle", int'(max_load), 1);

        exp_grants.push_back(0);
        exp_bytes.push_back(8'h0A);
        exp_bytes.push_back(8'h0C);
        request(0, 4'hA, 8'h0C);
        wait_frames(2, "req0_frame");

        exp_grants.push_back(1);
        exp_bytes.push_back(8'h01);
        exp_bytes.push_back(8'h3F);
        request(1, 4'h1, 8'h3F);
        wait_frames(3, "req1_frame");

        // Both requesters held for four back-to-back frames.
        for (int k = 0; k < 4; k++) begin
`ifdef MAX7219_ARB_FIXED_PRIO_EN
            exp_grants.push_back(0);
            exp_bytes.push_back(8'h02);
            exp_bytes.push_back(8'h11);
`else
            exp_grants.push_back(k % 2);
            exp_bytes.push_back((k % 2 == 0) ? 8'h02 : 8'h03);
            exp_bytes.push_back((k % 2 == 0) ? 8'h11 : 8'h22);
`endif
        end
        req_addr = {4'h3, 4'h2};
        req_data = {8'h22, 8'h11};
        req_valid = 2'b11;
        grants = 0;
        cyc = 0;
        while (grants < 4 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (req_ready != 2'b00) grants++;
        end
        req_valid = 2'b00;
        check_val("burst_grants", grants, 4);
        wait_frames(7, "burst_frames");
        check_val("load_hold_b2b", last_hi_len, int'(LH + GAP));

        // Reset while the low byte is shifting.
        exp_grants.push_back(0);
        exp_bytes.push_back(8'h0C);
        exp_bytes.push_back(8'h01);
        s0 = n_starts;
        request(0, 4'hC, 8'h01);
        wait_starts(s0 + 2, "lo_byte_started");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h00);
        @(negedge clk);
        check_reset_outputs("reset_mid_frame");
        rst = 1'b0;
        wait_frames(8, "flush_after_reset");

        repeat (10) @(negedge clk);
        check_val("leftover_bytes", exp_bytes.size(), 0);
        check_val("leftover_grants", exp_grants.size(), 0);
        check_val("idle_at_end", int'(idle), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
